sram_be_init: RTL and testbench
===============================

Name: sram_be_init

Overview:
- Parametrised single-port SRAM model: next generation of the team's generic compiled-RAM stand-in.
- Adds per-byte write enables, a selectable 1- or 2-cycle read pipeline with a valid strobe, and a hardware fill engine.
- The fill engine writes INIT_VALUE to every entry after reset or on request, and deasserts ready while it runs.
- Used for cache tag and data arrays that must start in a known state without a testbench preload.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address bits; ENTRIES = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits covered by each byte-enable bit; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry during fill.
- INIT_ON_RESET, 1, 1 = fill starts automatically when rst deasserts; 0 = come up ready, array contents undefined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- a  in  ADDR_WIDTH  access address.
- wd  in  DATA_WIDTH  write data.
- be  in  NUM_BYTES  byte write enables; bit i covers wd[i*BYTE_WIDTH +: BYTE_WIDTH].
- write  in  1  write request.
- read  in  1  read request.
- init_req  in  1  request a full-array fill.
- rd  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd carries data for an accepted read.
- ready  out  1  1 = read/write requests are accepted this cycle.
- init_done  out  1  one-cycle pulse after the last fill write.

Behaviour:
- Reset values:
  - rd = 0, rd_valid = 0, init_done = 0.
  - ready = 0 if INIT_ON_RESET = 1, else 1.
  - FSM = FILL with counter = 0 if INIT_ON_RESET = 1, else IDLE.
  - Array contents are not touched by reset.
- FSM states:
  - IDLE: ready = 1.
  - FILL: ready = 0. Each cycle writes INIT_VALUE to ram[cnt], then cnt++.
  - FILL takes exactly ENTRIES cycles. On cnt = ENTRIES-1: write that entry, go to IDLE, pulse init_done for one cycle, and raise ready the same cycle.
  - cnt is ADDR_WIDTH bits wide; the wrap to 0 coincides with the exit to IDLE.
- init_req:
  - Sampled in IDLE: FILL starts next cycle with cnt = 0. A read or write presented in that same cycle is still accepted.
  - Ignored while in FILL; it is not queued.
- Accept rules:
  - A request is accepted only when ready = 1.
  - read/write asserted while ready = 0 are dropped silently: no array change, no rd_valid.
- Write:
  - Byte i of ram[a] updates at the clock edge iff write & be[i].
  - write with be = 0 is a no-op.
- Read:
  - RD_LATENCY = 1: read accepted in cycle N gives rd/rd_valid in cycle N+1.
  - RD_LATENCY = 2: read accepted in cycle N gives rd/rd_valid in cycle N+2, through a second output register.
  - rd_valid is high for one cycle per accepted read; back-to-back reads give back-to-back valids.
- Read and write in the same cycle, same address: read-first. rd returns the pre-write data; the write still commits.
- rd holds its last valid value when rd_valid = 0. It never goes to X, unlike the previous model.
- A read accepted in the cycle before FILL begins completes normally with pre-fill data.
- rst asserted mid-FILL or mid-read:
  - Pipeline is cleared, rd_valid = 0.
  - FILL restarts from cnt = 0 on deassert if INIT_ON_RESET = 1.
  - Entries already filled keep INIT_VALUE.
- Simulation-time error on an illegal RD_LATENCY or when DATA_WIDTH % BYTE_WIDTH != 0.

Decomposition:
- Package sram_pkg holds:
  - FSM state localparams (ST_IDLE, ST_FILL).
  - Function num_bytes(dw, bw).
  - RD_LATENCY legality constants.
- One natural sub-module, sram_fill_fsm: state register, fill counter, ready and init_done generation. It outputs fill_we and fill_addr.
- The top level muxes the array write port between the user side and the fill engine, using ready as the select.
- The top level also owns the array and the read pipeline.

Test Plan (ADDR_WIDTH = 4, DATA_WIDTH = 32, BYTE_WIDTH = 8, INIT_VALUE = 32'hA5A5A5A5):
- Reset release with INIT_ON_RESET = 1 -> ready stays 0 for 16 cycles and init_done pulses in cycle 16. Then reading addresses 0..15 returns 32'hA5A5A5A5 with rd_valid one cycle after each read.
- Write a = 3, wd = 32'h11223344, be = 4'b0101, then read a = 3 -> rd = 32'hA522A544. Write with be = 0 followed by a read -> value unchanged.
- Read and write together, a = 5, wd = 32'hDEADBEEF, be = 4'hF -> rd = 32'hA5A5A5A5. The next read of a = 5 returns 32'hDEADBEEF.
- RD_LATENCY = 2, reads to a = 1, 2, 3 on consecutive cycles -> rd_valid high in cycles N+2..N+4, data in order. rd holds the a = 3 data afterwards.
- init_req in IDLE with a write to a = 7 in the same cycle -> the write lands, then the fill overwrites it. A read of a = 7 after init_done returns 32'hA5A5A5A5, and requests during FILL give no rd_valid.
- rst pulse at fill cycle 8 -> rd_valid = 0 immediately. Fill restarts and init_done arrives 16 cycles after rst falls.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg
// Shared definitions for the byte-enable SRAM model with hardware fill:
//   - fill engine state encoding
//   - legal read-latency range and a check helper
//   - byte-lane count helper
package sram_pkg;

  // Fill engine states: IDLE accepts user traffic, FILL owns the write port.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  // The read pipeline is either one or two registers deep.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int num_bytes(input int dw, input int bw);
    return dw / bw;
  endfunction

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_fill_fsm.sv
// sram_fill_fsm
// Fill engine for sram_be_init. Walks every array entry once, issuing one
// write per cycle, and tells the top level when the array belongs to users.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   init_req   - start a full fill (honoured only while idle)
//   ready      - 1 while idle; user reads/writes are accepted
//   init_done  - one-cycle pulse in the first idle cycle after a fill
//   fill_we    - fill write strobe for the array
//   fill_addr  - entry being filled this cycle
module sram_fill_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  ready,
  output logic                  init_done,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam fill_state_e           RESET_STATE = INIT_ON_RESET ? ST_FILL : ST_IDLE;

  fill_state_e           state;
  fill_state_e           state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_next;
  logic                  done_next;

  // State, counter and the done pulse are all registered so init_done lines
  // up with the first cycle that ready is high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_STATE;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_done <= done_next;
    end
  end

  // The counter wraps to zero on the last entry, which is exactly when the
  // engine drops back to idle, so it is already cleared for the next fill.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_req) begin
          state_next = ST_FILL;
          cnt_next   = '0;
        end
      end
      ST_FILL: begin
        cnt_next = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_ADDR) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are pure functions of the state register.
  always_comb begin
    ready     = (state == ST_IDLE);
    fill_we   = (state == ST_FILL);
    fill_addr = cnt;
  end

endmodule

// File: rtl/sram_be_init.sv
// sram_be_init
// Single-port SRAM model with per-byte write enables, a 1- or 2-cycle read
// pipeline with valid strobe, and a hardware fill engine that writes
// INIT_VALUE to every entry after reset (optional) or on request.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   a          - access address
//   wd, be     - write data and per-byte write enables
//   write/read - access requests, honoured only while ready = 1
//   init_req   - request a full-array fill
//   rd         - read data, holds its last value between valid reads
//   rd_valid   - one pulse per accepted read, RD_LATENCY cycles later
//   ready      - requests are accepted this cycle
//   init_done  - one-cycle pulse when a fill completes
module sram_be_init
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 10,
  parameter int                    BYTE_WIDTH    = 8,
  parameter int                    RD_LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter int                    INIT_ON_RESET = 1,
  localparam int                   NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [NUM_BYTES-1:0]  be,
  input  logic                  write,
  input  logic                  read,
  input  logic                  init_req,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  init_done
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("sram_be_init: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("sram_be_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [NUM_BYTES-1:0]  wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_accept;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  sram_fill_fsm #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .INIT_ON_RESET(INIT_ON_RESET != 0)
  ) u_fill (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .ready    (ready),
    .init_done(init_done),
    .fill_we  (fill_we),
    .fill_addr(fill_addr)
  );

  // Write-port mux: ready selects the user side, otherwise the fill engine
  // owns the port. Nothing is written while rst is held so reset never
  // disturbs the array contents.
  always_comb begin
    wr_be   = '0;
    wr_addr = a;
    wr_data = wd;
    if (!rst) begin
      if (ready) begin
        wr_be = write ? be : '0;
      end else begin
        wr_addr = fill_addr;
        wr_data = INIT_VALUE;
        wr_be   = {NUM_BYTES{fill_we}};
      end
    end
  end

  // Array write with byte lanes; no reset on the storage itself.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_accept = read & ready;

  // First read stage. The array read sees pre-edge contents, which gives
  // read-first behaviour for a same-address read and write. Data only
  // loads on an accepted read so rd holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_data <= mem[a];
      end
    end
  end

  // Optional second output register for the two-cycle read latency.
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rd       = s2_data;
    assign rd_valid = s2_valid;
  end else begin : g_lat1
    assign rd       = s1_data;
    assign rd_valid = s1_valid;
  end

endmodule

// File: tb/tb_sram_be_init.sv
// tb_sram_be_init
// Drives one latency-1 and one latency-2 instance with identical traffic and
// compares both against a behavioural model of the array, the fill sequence
// and the read return queue on every cycle, plus a few fixed known values.
module tb_sram_be_init;

  localparam int          AW      = 4;
  localparam int          DW      = 32;
  localparam int          NB      = 4;
  localparam int          ENTRIES = 16;
  localparam logic [31:0] INIT    = 32'hA5A5A5A5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [NB-1:0] be;
  logic          write;
  logic          read;
  logic          init_req;

  logic [DW-1:0] rd1, rd2;
  logic          rd_valid1, rd_valid2;
  logic          ready1, ready2;
  logic          init_done1, init_done2;

  int num_checks = 0;
  int num_errors = 0;

  sram_be_init #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(1),
    .INIT_VALUE(INIT), .INIT_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst(rst), .a(a), .wd(wd), .be(be), .write(write), .read(read),
    .init_req(init_req), .rd(rd1), .rd_valid(rd_valid1), .ready(ready1),
    .init_done(init_done1)
  );

  sram_be_init #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(2),
    .INIT_VALUE(INIT), .INIT_ON_RESET(1)
  ) dut2 (
    .clk(clk), .rst(rst), .a(a), .wd(wd), .be(be), .write(write), .read(read),
    .init_req(init_req), .rd(rd2), .rd_valid(rd_valid2), .ready(ready2),
    .init_done(init_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: array contents, a fill-in-progress flag with the next
  // entry to fill, and per-latency queues of pending read returns tagged
  // with the clock edge on which they must appear.
  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  logic [31:0] mmem [ENTRIES];
  bit          filling;
  int          fidx;
  int          edge_no;
  pend_t       q1[$];
  pend_t       q2[$];
  logic        ev1, ev2, edone;
  logic [31:0] er1, er2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      filling = 1'b1;
      fidx    = 0;
      q1.delete();
      q2.delete();
      ev1   = 1'b0;
      ev2   = 1'b0;
      er1   = '0;
      er2   = '0;
      edone = 1'b0;
    end else begin
      edge_no++;
      edone = 1'b0;
      if (!filling) begin
        if (read) begin
          q1.push_back('{due: edge_no,     data: mmem[a]});
          q2.push_back('{due: edge_no + 1, data: mmem[a]});
        end
        if (write) begin
          for (int i = 0; i < NB; i++) begin
            if (be[i]) mmem[a][8*i +: 8] = wd[8*i +: 8];
          end
        end
        if (init_req) begin
          filling = 1'b1;
          fidx    = 0;
        end
      end else begin
        mmem[fidx] = INIT;
        fidx++;
        if (fidx == ENTRIES) begin
          filling = 1'b0;
          edone   = 1'b1;
        end
      end
      ev1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == edge_no) begin
        ev1 = 1'b1;
        er1 = q1[0].data;
        void'(q1.pop_front());
      end
      ev2 = 1'b0;
      if (q2.size() > 0 && q2[0].due == edge_no) begin
        ev2 = 1'b1;
        er2 = q2[0].data;
        void'(q2.pop_front());
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every falling edge, both instances are compared to the model.
  always @(negedge clk) begin
    checkOutput("ready_l1", 32'(ready1), 32'(!filling));
    checkOutput("ready_l2", 32'(ready2), 32'(!filling));
    checkOutput("done_l1", 32'(init_done1), 32'(edone));
    checkOutput("done_l2", 32'(init_done2), 32'(edone));
    checkOutput("valid_l1", 32'(rd_valid1), 32'(ev1));
    checkOutput("valid_l2", 32'(rd_valid2), 32'(ev2));
    checkOutput("rd_l1", rd1, er1);
    checkOutput("rd_l2", rd2, er2);
  end

  // One cycle of stimulus, applied just after the falling edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [NB-1:0] ben,
                               input logic ireq);
    @(negedge clk);
    #1;
    read     = r;
    write    = w;
    a        = addr;
    wd       = wdata;
    be       = ben;
    init_req = ireq;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic doReset(input int ncycles);
    @(negedge clk);
    #1;
    read     = 1'b0;
    write    = 1'b0;
    init_req = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("rst_valid_l1", 32'(rd_valid1), 32'd0);
    checkOutput("rst_valid_l2", 32'(rd_valid2), 32'd0);
    repeat (ncycles) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits for init_done and checks how many edges the fill took. Optional
  // noise issues requests while busy; writes avoid entries 0..7 so the
  // fixed-value checks afterwards stay predictable.
  task automatic waitFillDone(input int exp_edges, input bit noisy);
    for (int k = 1; k <= 40; k++) begin
      if (noisy)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'(8 + $urandom_range(0, 7)), $urandom, NB'($urandom_range(0, 15)), 1'b0);
      else
        idleCycle();
      if (init_done1 === 1'b1) begin
        checkOutput("fill_len", 32'(k), 32'(exp_edges));
        return;
      end
    end
    checkOutput("fill_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    read     = 1'b0;
    write    = 1'b0;
    init_req = 1'b0;
    a        = '0;
    wd       = '0;
    be       = '0;
    rst      = 1'b0;
    edge_no  = 0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_ready", 32'(ready1), 32'd0);
    checkOutput("reset_rd", rd1, 32'd0);
    checkOutput("reset_done", 32'(init_done1), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    $display("[TB] power-on fill");
    waitFillDone(16, 1'b0);

    // Every entry reads back as the fill value.
    for (int i = 0; i < ENTRIES; i++) applyStimulus(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
    idleCycle();
    idleCycle();

    // Partial byte write, then a write with no lanes enabled.
    applyStimulus(1'b0, 1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
    idleCycle();
    checkOutput("be_merge", rd1, 32'hA522A544);
    applyStimulus(1'b0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
    idleCycle();
    checkOutput("be_zero", rd1, 32'hA522A544);

    // Same-address read and write returns the old word.
    applyStimulus(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    idleCycle();
    checkOutput("rd_first", rd1, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b0, 4'd5, '0, '0, 1'b0);
    idleCycle();
    checkOutput("rd_after_wr", rd1, 32'hDEADBEEF);

    // Back-to-back reads; the two-cycle instance must hold the last word.
    applyStimulus(1'b1, 1'b0, 4'd1, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd2, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("lat2_hold", rd2, 32'hA522A544);
    checkOutput("lat2_idle_valid", 32'(rd_valid2), 32'd0);

    // Fill request with a write in the same cycle, noisy traffic while busy.
    $display("[TB] requested fill");
    applyStimulus(1'b0, 1'b1, 4'd7, 32'h12345678, 4'hF, 1'b1);
    waitFillDone(17, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd7, '0, '0, 1'b0);
    idleCycle();
    checkOutput("fill_overwrite", rd1, 32'hA5A5A5A5);

    // Reset in the middle of a fill restarts it from entry zero.
    $display("[TB] reset mid-fill");
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (8) idleCycle();
    doReset(1);
    waitFillDone(16, 1'b0);

    // Reset with reads in flight clears both pipelines.
    $display("[TB] reset mid-read");
    applyStimulus(1'b1, 1'b0, 4'd1, '0, '0, 1'b0);
    doReset(2);
    waitFillDone(16, 1'b0);

    // Random traffic with occasional fill requests.
    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, ENTRIES - 1)), $urandom,
                    NB'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0));
    end
    repeat (20) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
